// File: rtl/io_out_bank.sv
// io_out_bank: memory-mapped output subsystem on the CPU data bus.
//
// NUM_CH buffered output channels, each a first-word-fall-through FIFO drained
// by a valid/ready consumer. A write to BASE_ADDR+k pushes into channel k. A
// write to a full channel raises stall (the CPU holds its PC and re-presents the
// write) unless the consumer pops that same cycle. A read of BASE_ADDR+NUM_CH
// returns a status word: bits [NUM_CH-1:0] are per-channel "not full" and bits
// [2*NUM_CH-1:NUM_CH] are per-channel "valid".
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   bus_addr   CPU bus address
//   bus_wdata  CPU write data
//   write      CPU write strobe
//   read       CPU read strobe
//   bus_rdata  status read data, 0 unless rd_hit
//   rd_hit     read targets the status address
//   stall      write hit to a full channel that cannot accept this cycle
//   ch_data    FIFO head per channel, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ch_valid   channel FIFO non-empty
//   ch_ready   consumer accepts the head this cycle
//   solution   last accepted channel write, any channel
//   overflow   sticky per channel: a write stalled on it at least once

module io_out_bank #(
  parameter int unsigned           ADDR_WIDTH = 20,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           NUM_CH     = 4,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'('hF0000)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_WIDTH-1:0]        bus_addr,
  input  logic [DATA_WIDTH-1:0]        bus_wdata,
  input  logic                         write,
  input  logic                         read,
  output logic [DATA_WIDTH-1:0]        bus_rdata,
  output logic                         rd_hit,
  output logic                         stall,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]        solution,
  output logic [NUM_CH-1:0]            overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]      FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE     = PTR_W'(1);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + ADDR_WIDTH'(NUM_CH);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] valid;

  logic [DATA_WIDTH-1:0] solution_q;
  logic [NUM_CH-1:0]     overflow_q;
  logic [DATA_WIDTH-1:0] status;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [ADDR_WIDTH-1:0] CH_ADDR = BASE_ADDR + ADDR_WIDTH'(k);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Gating with reset_n keeps stall low while reset is held.
    assign hit[k]   = reset_n & write & (bus_addr == CH_ADDR);
    assign valid[k] = (count_q != '0);
    assign full[k]  = (count_q == FULL_CNT);
    assign pop[k]   = valid[k] & ch_ready[k];
    // A full channel still accepts when its head leaves in the same cycle.
    assign acc[k]   = hit[k] & (~full[k] | pop[k]);

    assign ch_data[k*DATA_WIDTH +: DATA_WIDTH] = valid[k] ? mem_q[rd_ptr_q] : '0;

    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (acc[k]) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop[k]) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({acc[k], pop[k]})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage needs no reset: ch_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
      if (acc[k]) begin
        mem_q[wr_ptr_q] <= bus_wdata;
      end
    end
  end

  assign ch_valid = valid;
  assign stall    = |(hit & ~acc);
  assign rd_hit   = reset_n & read & (bus_addr == STATUS_ADDR);

  always_comb begin
    status                      = '0;
    status[NUM_CH-1:0]          = ~full;
    status[2*NUM_CH-1:NUM_CH]   = valid;
  end

  assign bus_rdata = rd_hit ? status : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      solution_q <= '0;
      overflow_q <= '0;
    end else begin
      // At most one channel address matches, so any accept carries bus_wdata.
      if (|acc) begin
        solution_q <= bus_wdata;
      end
      overflow_q <= overflow_q | (hit & ~acc);
    end
  end

  assign solution = solution_q;
  assign overflow = overflow_q;

endmodule
